// File: rtl/uart_tx_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one uart_tx between two requesters,
//            each backed by a one-entry holding buffer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int DATA_W        = 7,
    parameter int START_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic              sent0,
    output logic              sent1,
    output logic              cur_src,
    output logic              timeout_err
);

    localparam int c_CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                w_valid    [2];
    logic [DATA_W-1:0]   w_req_data [2];
    logic                r_full     [2];
    logic                r_seen     [2];
    logic [DATA_W-1:0]   r_buf      [2];
    logic                w_elig     [2];
    logic                w_clr      [2];

    logic [DATA_W-1:0]   r_tx_data;
    logic                r_cur_src;
    logic                r_last_grant;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_sent0;
    logic                r_sent1;
    logic                r_timeout_err;

    logic                w_any;
    logic                w_win;
    logic                w_cnt_last;
    logic                w_done;
    logic                w_timeout;

    assign w_valid[0]    = req0_valid;
    assign w_valid[1]    = req1_valid;
    assign w_req_data[0] = req0_data;
    assign w_req_data[1] = req1_data;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_done     = (r_state == ST_WAIT_DONE) && !tx_busy;
    assign w_timeout  = (r_state == ST_WAIT_BUSY) && !tx_busy && w_cnt_last;

    // A freshly loaded buffer gets one settle cycle (r_seen) before it may win.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            localparam logic c_IDX = 1'(gi);

            assign w_elig[gi] = r_full[gi] & r_seen[gi];
            assign w_clr[gi]  = (w_done | w_timeout) & (r_cur_src == c_IDX);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_full[gi] <= 1'b0;
                    r_seen[gi] <= 1'b0;
                    r_buf[gi]  <= '0;
                end else begin
                    r_seen[gi] <= r_full[gi];
                    if (w_clr[gi]) begin
                        r_full[gi] <= 1'b0;
                    end else if (w_valid[gi] && !r_full[gi]) begin
                        r_full[gi] <= 1'b1;
                        r_buf[gi]  <= w_req_data[gi];
                    end
                end
            end
        end
    endgenerate

    assign w_any = w_elig[0] | w_elig[1];
    assign w_win = (w_elig[0] & w_elig[1]) ? ~r_last_grant : w_elig[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_any) w_state_nxt = ST_START;
            ST_START:     w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (w_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: if (!tx_busy) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_data     <= '0;
            r_cur_src     <= 1'b0;
            r_last_grant  <= 1'b1;
            r_cnt         <= '0;
            r_sent0       <= 1'b0;
            r_sent1       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_sent0 <= 1'b0;
            r_sent1 <= 1'b0;
            if ((r_state == ST_IDLE) && w_any) begin
                r_tx_data <= w_win ? r_buf[1] : r_buf[0];
                r_cur_src <= w_win;
            end
            if (r_state == ST_START) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT_BUSY) && !tx_busy && !w_cnt_last) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
                r_last_grant  <= r_cur_src;
            end
            if (w_done) begin
                r_last_grant <= r_cur_src;
                r_sent0      <= ~r_cur_src;
                r_sent1      <= r_cur_src;
            end
        end
    end

    assign req0_ready  = ~r_full[0];
    assign req1_ready  = ~r_full[1];
    assign tx_start    = (r_state == ST_START);
    assign tx_data     = r_tx_data;
    assign cur_src     = r_cur_src;
    assign sent0       = r_sent0;
    assign sent1       = r_sent1;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
